// File: rtl/multi_warp_tag_queue.sv
// multi_warp_tag_queue: per-warp free-list allocator for inflight-instruction tags.
// Each warp owns a NumTags-bit free bitmap (1 = free). One allocation per warp per
// cycle, NumFreePorts returns per cycle to any warp. Within a cycle, get-clears are
// applied before free-sets, so a free always wins a collision.
// Optional feature macro: MULTI_WARP_TAG_QUEUE_DOUBLE_FREE_CHECK_EN enables the
// double-free detector that drives error_o; without it error_o is tied to 0.

module multi_warp_tag_queue_lane #(
  parameter int NumTags    = 16,
  parameter int TagWidth   = $clog2(NumTags),
  parameter int CountWidth = $clog2(NumTags + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_get,
  input  logic [NumTags-1:0]    i_set,
  output logic                  o_valid,
  output logic [TagWidth-1:0]   o_tag,
  output logic [CountWidth-1:0] o_count,
  output logic [NumTags-1:0]    o_bitmap
);

  logic [NumTags-1:0]    r_bitmap;
  logic [NumTags-1:0]    w_clr;
  logic [TagWidth-1:0]   w_tag;
  logic [CountWidth-1:0] w_count;

  // Lowest free tag (scan high to low so the lowest index wins) and free count.
  always_comb begin
    w_tag   = '0;
    w_count = '0;
    for (int i = NumTags - 1; i >= 0; i--) begin
      if (r_bitmap[i]) w_tag = TagWidth'(i);
    end
    for (int i = 0; i < NumTags; i++) begin
      w_count = w_count + CountWidth'(r_bitmap[i]);
    end
  end

  assign o_valid  = |r_bitmap;
  assign o_tag    = w_tag;
  assign o_count  = w_count;
  assign o_bitmap = r_bitmap;
  // A get without a free tag is dropped here.
  assign w_clr    = (i_get && o_valid) ? (NumTags'(1) << w_tag) : '0;

  // Bitmap update: clear the allocated tag first, then OR in returned tags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_bitmap <= '1;
    else         r_bitmap <= (r_bitmap & ~w_clr) | i_set;
  end

endmodule

module multi_warp_tag_queue #(
  parameter int NumWarps     = 4,
  parameter int NumTags      = 16,
  parameter int NumFreePorts = 2,
  parameter int TagWidth     = $clog2(NumTags),
  parameter int WarpWidth    = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  parameter int CountWidth   = $clog2(NumTags + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumWarps-1:0]               get_i,
  output logic [NumWarps-1:0]               valid_o,
  output logic [NumWarps*TagWidth-1:0]      tag_o,
  input  logic [NumFreePorts-1:0]           free_i,
  input  logic [NumFreePorts*WarpWidth-1:0] free_warp_i,
  input  logic [NumFreePorts*TagWidth-1:0]  free_tag_i,
  output logic [NumWarps*CountWidth-1:0]    num_free_o,
  output logic                              error_o
);

  logic [NumWarps-1:0][NumTags-1:0] w_set;
  logic [NumWarps-1:0][NumTags-1:0] w_bitmap;
  logic [WarpWidth-1:0]             w_fw [NumFreePorts];
  logic [TagWidth-1:0]              w_ft [NumFreePorts];

  for (genvar p = 0; p < NumFreePorts; p++) begin : g_port
    assign w_fw[p] = free_warp_i[p*WarpWidth +: WarpWidth];
    assign w_ft[p] = free_tag_i[p*TagWidth +: TagWidth];
  end

  // Route each return strobe to its warp; warp ids past NumWarps match no lane.
  always_comb begin
    w_set = '0;
    for (int w = 0; w < NumWarps; w++) begin
      for (int p = 0; p < NumFreePorts; p++) begin
        if (free_i[p] && (w_fw[p] == WarpWidth'(w))) w_set[w][w_ft[p]] = 1'b1;
      end
    end
  end

  for (genvar w = 0; w < NumWarps; w++) begin : g_lane
    multi_warp_tag_queue_lane #(
      .NumTags   (NumTags),
      .TagWidth  (TagWidth),
      .CountWidth(CountWidth)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_get   (get_i[w]),
      .i_set   (w_set[w]),
      .o_valid (valid_o[w]),
      .o_tag   (tag_o[w*TagWidth +: TagWidth]),
      .o_count (num_free_o[w*CountWidth +: CountWidth]),
      .o_bitmap(w_bitmap[w])
    );
  end

`ifdef MULTI_WARP_TAG_QUEUE_DOUBLE_FREE_CHECK_EN
  logic w_dbl;
  logic r_error;

  // Double free: returning a tag already free before the edge, or two ports
  // returning the same valid warp/tag pair in one cycle.
  always_comb begin
    w_dbl = 1'b0;
    for (int p = 0; p < NumFreePorts; p++) begin
      for (int w = 0; w < NumWarps; w++) begin
        if (free_i[p] && (w_fw[p] == WarpWidth'(w)) && w_bitmap[w][w_ft[p]]) w_dbl = 1'b1;
      end
      for (int q = p + 1; q < NumFreePorts; q++) begin
        if (free_i[p] && free_i[q] && (w_fw[p] == w_fw[q]) && (w_ft[p] == w_ft[q]) &&
            (int'(w_fw[p]) < NumWarps)) w_dbl = 1'b1;
      end
    end
  end

  // Registered one-cycle error pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_error <= 1'b0;
    else         r_error <= w_dbl;
  end

`ifndef SYNTHESIS
  // Name the offending warp/tag in simulation logs.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int p = 0; p < NumFreePorts; p++) begin
        if (free_i[p] && (int'(w_fw[p]) < NumWarps) && w_bitmap[w_fw[p]][w_ft[p]])
          $error("double free: warp %0d tag %0d (already free)", w_fw[p], w_ft[p]);
        for (int q = p + 1; q < NumFreePorts; q++) begin
          if (free_i[p] && free_i[q] && (w_fw[p] == w_fw[q]) && (w_ft[p] == w_ft[q]) &&
              (int'(w_fw[p]) < NumWarps))
            $error("double free: warp %0d tag %0d (two ports)", w_fw[p], w_ft[p]);
        end
      end
    end
  end
`endif

  assign error_o = r_error;
`else
  logic w_unused_bitmap;
  assign w_unused_bitmap = ^w_bitmap;
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_multi_warp_tag_queue.sv
// Bench for multi_warp_tag_queue (NumWarps=4, NumTags=8, NumFreePorts=2):
// a hand-computed vector table driven through a scoreboard queue, hand-written
// bypass/reset sequences, and a random soak against an outstanding-tag model.
module tb_multi_warp_tag_queue;

`ifdef MULTI_WARP_TAG_QUEUE_DOUBLE_FREE_CHECK_EN
  localparam logic DF = 1'b1;
`else
  localparam logic DF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  get_i;
  logic [3:0]  valid_o;
  logic [11:0] tag_o;
  logic [1:0]  free_i;
  logic [3:0]  free_warp_i;
  logic [5:0]  free_tag_i;
  logic [15:0] num_free_o;
  logic        error_o;

  int checks   = 0;
  int failures = 0;

  multi_warp_tag_queue #(.NumWarps(4), .NumTags(8), .NumFreePorts(2)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .get_i      (get_i),
    .valid_o    (valid_o),
    .tag_o      (tag_o),
    .free_i     (free_i),
    .free_warp_i(free_warp_i),
    .free_tag_i (free_tag_i),
    .num_free_o (num_free_o),
    .error_o    (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst_n;
    logic [3:0]  get;
    logic [1:0]  fr;
    logic [3:0]  fw;
    logic [5:0]  ft;
    logic [3:0]  ev;
    logic [11:0] et;
    logic [15:0] ec;
    logic        ee;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic logic [11:0] tg(input int t0, t1, t2, t3);
    return {3'(t3), 3'(t2), 3'(t1), 3'(t0)};
  endfunction

  function automatic logic [15:0] cn(input int c0, c1, c2, c3);
    return {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] g, input logic [1:0] fr,
                              input logic [3:0] fw, input logic [5:0] ft, input logic [3:0] ev,
                              input logic [11:0] et, input logic [15:0] ec, input logic ee);
    vec_t v;
    v.rst_n = r; v.get = g; v.fr = fr; v.fw = fw; v.ft = ft;
    v.ev = ev; v.et = et; v.ec = ec; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] g, input logic [1:0] fr,
                       input logic [3:0] fw, input logic [5:0] ft);
    rst_ni = r; get_i = g; free_i = fr; free_warp_i = fw; free_tag_i = ft;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [7:0] outst [4];

  initial begin
    vec_t v;
    // ---------------- vector table ----------------
    // Reset then drain warp 0 with 9 gets.
    for (int k = 1; k <= 9; k++) begin
      int kk;
      kk = (k < 8) ? k : 8;
      vecs.push_back(mk(1, 4'b0001, 2'b00, 4'h0, 6'h0, (kk < 8) ? 4'hF : 4'hE,
                        tg((kk < 8) ? kk : 0, 0, 0, 0), cn(8 - kk, 8, 8, 8), 0));
    end
    // Empty pool: free + get in one cycle -> get ignored, count 1.
    vecs.push_back(mk(1, 4'b0001, 2'b01, 4'h0, {3'd0, 3'd5}, 4'hF, tg(5,0,0,0), cn(1,8,8,8), 0));
    vecs.push_back(mk(1, 4'b0001, 2'b00, 4'h0, 6'h0,         4'hE, tg(0,0,0,0), cn(0,8,8,8), 0));
    // Return 5 and 2 together, then reuse.
    vecs.push_back(mk(1, 4'b0000, 2'b11, 4'h0, {3'd2, 3'd5}, 4'hF, tg(2,0,0,0), cn(2,8,8,8), 0));
    vecs.push_back(mk(1, 4'b0001, 2'b00, 4'h0, 6'h0,         4'hF, tg(5,0,0,0), cn(1,8,8,8), 0));
    // Warp 1 holds {0,1}, then get + free tag 0 in the same cycle.
    vecs.push_back(mk(1, 4'b0010, 2'b00, 4'h0, 6'h0,         4'hF, tg(5,1,0,0), cn(1,7,8,8), 0));
    vecs.push_back(mk(1, 4'b0010, 2'b00, 4'h0, 6'h0,         4'hF, tg(5,2,0,0), cn(1,6,8,8), 0));
    vecs.push_back(mk(1, 4'b0010, 2'b01, {2'd0, 2'd1}, 6'h0, 4'hF, tg(5,0,0,0), cn(1,6,8,8), 0));
    // Double free of a still-free tag on warp 2.
    vecs.push_back(mk(1, 4'b0000, 2'b01, {2'd0, 2'd2}, {3'd0, 3'd3}, 4'hF, tg(5,0,0,0), cn(1,6,8,8), DF));
    vecs.push_back(mk(1, 4'b0000, 2'b00, 4'h0, 6'h0,         4'hF, tg(5,0,0,0), cn(1,6,8,8), 0));
    // Allocate warp 2 tags 0..3, then free tag 3 on both ports.
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk(1, 4'b0100, 2'b00, 4'h0, 6'h0, 4'hF, tg(5,0,k,0), cn(1,6,8-k,8), 0));
    vecs.push_back(mk(1, 4'b0000, 2'b11, {2'd2, 2'd2}, {3'd3, 3'd3}, 4'hF, tg(5,0,3,0), cn(1,6,5,8), DF));
    vecs.push_back(mk(1, 4'b0000, 2'b00, 4'h0, 6'h0,         4'hF, tg(5,0,3,0), cn(1,6,5,8), 0));
    // All warps get at once.
    vecs.push_back(mk(1, 4'b1111, 2'b00, 4'h0, 6'h0,         4'hE, tg(0,3,4,1), cn(0,5,4,7), 0));
    // Mid-operation reset wins over concurrent get/free.
    vecs.push_back(mk(0, 4'b1111, 2'b11, {2'd1, 2'd0}, {3'd1, 3'd2}, 4'hF, tg(0,0,0,0), cn(8,8,8,8), 0));
    vecs.push_back(mk(1, 4'b0000, 2'b00, 4'h0, 6'h0,         4'hF, tg(0,0,0,0), cn(8,8,8,8), 0));

    // ---------------- initial reset ----------------
    drive(0, 4'h0, 2'b00, 4'h0, 6'h0);
    tick(); tick();
    chk("rst_valid", 0, 32'(valid_o), 32'hF);
    chk("rst_tag",   0, 32'(tag_o), 32'h0);
    chk("rst_count", 0, 32'(num_free_o), 32'h8888);
    chk("rst_error", 0, 32'(error_o), 32'h0);

    // ---------------- table through scoreboard ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst_n, v.get, v.fr, v.fw, v.ft);
      sb.push_back(v);
      tick();
      v = sb.pop_front();
      chk("vec_valid", i, 32'(valid_o), 32'(v.ev));
      chk("vec_tag",   i, 32'(tag_o), 32'(v.et));
      chk("vec_count", i, 32'(num_free_o), 32'(v.ec));
      chk("vec_error", i, 32'(error_o), 32'(v.ee));
    end

    // ---------------- no same-cycle bypass ----------------
    drive(1, 4'b0001, 2'b00, 4'h0, 6'h0);
    repeat (8) tick();
    drive(1, 4'b0000, 2'b01, 4'h0, {3'd0, 3'd6});
    #1;
    chk("nobypass_valid", 0, 32'(valid_o[0]), 32'h0);
    chk("nobypass_count", 0, 32'(num_free_o[3:0]), 32'h0);
    tick();
    drive(1, 4'b0000, 2'b00, 4'h0, 6'h0);
    chk("ret_valid", 0, 32'(valid_o[0]), 32'h1);
    chk("ret_tag",   0, 32'(tag_o[2:0]), 32'h6);
    chk("ret_count", 0, 32'(num_free_o[3:0]), 32'h1);

    // ---------------- random soak ----------------
    drive(0, 4'h0, 2'b00, 4'h0, 6'h0);
    tick();
    rst_ni = 1'b1;
    for (int w = 0; w < 4; w++) outst[w] = 8'h00;
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] g;
      logic [1:0] fr;
      logic [1:0] fwp [2];
      logic [2:0] ftp [2];
      for (int w = 0; w < 4; w++) begin
        chk("soak_count", c, 32'(num_free_o[w*4 +: 4]), 32'(8 - $countones(outst[w])));
        chk("soak_valid", c, 32'(valid_o[w]), 32'(outst[w] != 8'hFF));
        if (valid_o[w]) chk("soak_unique", c, 32'(outst[w][tag_o[w*3 +: 3]]), 32'h0);
      end
      chk("soak_error", c, 32'(error_o), 32'h0);
      g  = 4'($urandom);
      fr = 2'b00;
      for (int p = 0; p < 2; p++) begin
        int w, off;
        fwp[p] = 2'd0; ftp[p] = 3'd0;
        w   = $urandom_range(0, 3);
        off = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1 && outst[w] != 8'h00) begin
          for (int j = 0; j < 8; j++) begin
            if (!fr[p] && outst[w][(off + j) % 8]) begin
              fr[p] = 1'b1; fwp[p] = 2'(w); ftp[p] = 3'((off + j) % 8);
            end
          end
          if (p == 1 && fr[0] && fwp[0] == fwp[1] && ftp[0] == ftp[1]) fr[1] = 1'b0;
        end
      end
      drive(1, g, fr, {fwp[1], fwp[0]}, {ftp[1], ftp[0]});
      for (int w = 0; w < 4; w++)
        if (g[w] && valid_o[w]) outst[w][tag_o[w*3 +: 3]] = 1'b1;
      for (int p = 0; p < 2; p++)
        if (fr[p]) outst[fwp[p]][ftp[p]] = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
